vernam_decipher: RTL

Receiving end of the Vernam link. It captures ciphertext bytes that a PicoBlaze writes over its port bus (port_id / out_port / write_strobe) and pulls exactly one key byte per ciphertext byte from the key-stream generator over a req/ack handshake. It XORs the two bytes and buffers the plaintext in a FIFO, which a receiving PicoBlaze drains through its input mux.

---
 rtl/vernam_decipher.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vernam_decipher.sv
// Vernam receiver: captures ciphertext from a PicoBlaze port write, XORs it with one key byte and queues the plaintext.
// Latency: capture to pt_valid is 3 edges when key_ack is held high.
// Backpressure: a full FIFO stalls the FSM in IDLE; captures into an occupied cbuf are dropped and flagged.

module vernam_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic             head_vld,
    output logic [PTR_W:0]   count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign empty   = (count == '0);
    assign full    = count[PTR_W];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    assign head_vld = !empty;
    assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

module vernam_decipher #(
    parameter logic [7:0] CIPHER_PORT = 8'h80,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         PTR_W       = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       port_id,
    input  logic [7:0]       out_port,
    input  logic             write_strobe,
    output logic             key_req,
    input  logic             key_ack,
    input  logic [7:0]       key_data,
    output logic [7:0]       pt_data,
    output logic             pt_valid,
    input  logic             pt_read,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow,
    output logic             busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] KEY_REQ = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;

    logic [1:0] state;
    logic [7:0] cbuf;
    logic       cbuf_full;
    logic [7:0] pt_reg;
    logic       capture;
    logic       clear;
    logic       accept;
    logic       fifo_full;

    assign capture   = write_strobe && (port_id == CIPHER_PORT);
    assign clear     = (state == WRITE);
    // A byte arriving on the clearing edge takes the slot being vacated.
    assign accept    = capture && (!cbuf_full || clear);
    assign fifo_full = fifo_count[PTR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cbuf      <= 8'h00;
            cbuf_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                cbuf      <= out_port;
                cbuf_full <= 1'b1;
            end else if (clear) begin
                cbuf_full <= 1'b0;
            end
            if (capture && cbuf_full && !clear) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            key_req <= 1'b0;
            pt_reg  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (cbuf_full && !fifo_full) begin
                        state   <= KEY_REQ;
                        key_req <= 1'b1;
                    end
                end
                KEY_REQ: begin
                    if (key_ack) begin
                        pt_reg  <= cbuf ^ key_data;
                        key_req <= 1'b0;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    key_req <= 1'b0;
                end
            endcase
        end
    end

    vernam_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (clear),
        .push_dat (pt_reg),
        .pop      (pt_read),
        .head_dat (pt_data),
        .head_vld (pt_valid),
        .count    (fifo_count)
    );

    assign busy = (state != IDLE) || cbuf_full;
endmodule
